// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared I/Q types for the time-multiplexer / deinterleaver pair
//
// Purpose : common word width, complex sample struct and the lock FSM
//           state type used on both sides of the 2x-rate I/Q link.
// Ports   : none (package).

package iq_pkg;

  // Native I/Q word width of the link.
  localparam int IQ_DATA_W = 16;

  // One complex sample as carried between the two halves of the link.
  typedef struct packed {
    logic signed [IQ_DATA_W-1:0] re;
    logic signed [IQ_DATA_W-1:0] im;
  } iq_sample_t;

  // Alternation lock tracking on the receive side.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } iq_lock_state_t;

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear
//
// Purpose : counts inc_i pulses, sticks at all-ones, clr_i has priority
//           over inc_i in the same cycle.
// Ports   :
//   clk_i  in   1   clock, posedge
//   rst_i  in   1   asynchronous reset, active-high
//   inc_i  in   1   increment request
//   clr_i  in   1   synchronous clear (wins over inc_i)
//   cnt_o  out  W   current count

module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic at_max;

  assign at_max = (cnt_o == {W{1'b1}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && !at_max) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/iq_deinterleave.sv
// rtl/iq_deinterleave.sv - rebuilds complex pairs from the 2x-rate interleaved I/Q stream
//
// Purpose : receive half of the I/Q time-multiplexer. Samples one word per
//           fast clock, tracks real/imag flag alternation, declares lock after
//           LOCK_CNT consecutive alternations, and once locked emits each
//           real->imag pair with a one-cycle valid strobe. Repeated flags while
//           locked are sequence errors: pulsed on err_o and counted.
// Ports   :
//   clk_i      in   1          fast (2x) clock, posedge
//   rst_i      in   1          asynchronous reset, active-high
//   data_i     in   DATA_W     signed interleaved word, one per cycle
//   re_p_im_i  in   1          1 = data_i is real, 0 = imaginary
//   err_clr_i  in   1          synchronous clear of err_cnt_o
//   data_re_o  out  DATA_W     reassembled real part (held between strobes)
//   data_im_o  out  DATA_W     reassembled imaginary part (held between strobes)
//   valid_o    out  1          one-cycle strobe for a new pair
//   locked_o   out  1          alternation locked
//   err_o      out  1          one-cycle pulse per sequence error while locked
//   err_cnt_o  out  ERR_CNT_W  saturating sequence error count

module iq_deinterleave #(
  parameter int DATA_W    = 16,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     re_p_im_i,
  input  logic                     err_clr_i,
  output logic signed [DATA_W-1:0] data_re_o,
  output logic signed [DATA_W-1:0] data_im_o,
  output logic                     valid_o,
  output logic                     locked_o,
  output logic                     err_o,
  output logic [ERR_CNT_W-1:0]     err_cnt_o
);

  import iq_pkg::*;

  localparam int ALT_W = $clog2(LOCK_CNT + 1);
  // Count value at which the next alternation completes the lock.
  localparam logic [ALT_W-1:0] ALT_LAST = ALT_W'(LOCK_CNT - 1);

  iq_lock_state_t           state;
  iq_lock_state_t           state_nxt;
  logic [ALT_W-1:0]         alt_cnt;
  logic [ALT_W-1:0]         alt_cnt_nxt;
  logic                     prev_vld;
  logic                     prev_flag;
  logic signed [DATA_W-1:0] re_hold;

  logic alt_evt;
  logic seq_err;
  logic pair_fire;
  logic err_fire;

  // Flag relation to the previous sample; both are meaningless before the
  // first sample after reset, hence the prev_vld qualifier.
  assign alt_evt = prev_vld && (re_p_im_i != prev_flag);
  assign seq_err = prev_vld && (re_p_im_i == prev_flag);

  // ---------------------------------------------------------------------
  // Lock FSM: next state and per-sample decisions
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    alt_cnt_nxt = alt_cnt;
    pair_fire   = 1'b0;
    err_fire    = 1'b0;

    unique case (state)
      UNLOCKED: begin
        // First sample only establishes prev_flag; nothing to compare yet.
        state_nxt   = LOCKING;
        alt_cnt_nxt = '0;
      end

      LOCKING: begin
        if (alt_evt) begin
          if (alt_cnt == ALT_LAST) begin
            state_nxt   = LOCKED;
            alt_cnt_nxt = '0;
          end else begin
            alt_cnt_nxt = alt_cnt + ALT_W'(1);
          end
        end else if (seq_err) begin
          // Unlocked errors only restart the alternation count.
          alt_cnt_nxt = '0;
        end
      end

      LOCKED: begin
        if (seq_err) begin
          // Drop back to re-acquire; the pending real word cannot complete a
          // pair because pairing requires the LOCKED state again.
          err_fire    = 1'b1;
          state_nxt   = LOCKING;
          alt_cnt_nxt = '0;
        end else if (!re_p_im_i && prev_flag) begin
          // Imaginary word directly following a real word: complete pair.
          pair_fire = 1'b1;
        end
      end

      default: begin
        state_nxt   = UNLOCKED;
        alt_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State, sample history and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= UNLOCKED;
      alt_cnt   <= '0;
      prev_vld  <= 1'b0;
      prev_flag <= 1'b0;
      re_hold   <= '0;
      locked_o  <= 1'b0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      data_re_o <= '0;
      data_im_o <= '0;
    end else begin
      state     <= state_nxt;
      alt_cnt   <= alt_cnt_nxt;
      prev_vld  <= 1'b1;
      prev_flag <= re_p_im_i;

      // Every real word is captured regardless of lock state so that a pair
      // straddling the lock-entry edge still has its real part available.
      if (re_p_im_i) begin
        re_hold <= data_i;
      end

      locked_o <= (state_nxt == LOCKED);
      valid_o  <= pair_fire;
      err_o    <= err_fire;

      if (pair_fire) begin
        data_re_o <= re_hold;
        data_im_o <= data_i;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequence error counter (clear wins over a coincident error)
  // ---------------------------------------------------------------------
  sat_cnt #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (err_fire),
    .clr_i (err_clr_i),
    .cnt_o (err_cnt_o)
  );

endmodule

// File: tb/tb_iq_deinterleave.sv
// tb/tb_iq_deinterleave.sv - self-checking bench for iq_deinterleave

module tb_iq_deinterleave;

  import iq_pkg::*;

  localparam int DATA_W   = 16;
  localparam int LOCK_CNT = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic signed [DATA_W-1:0] data_i;
  logic                     re_p_im_i;
  logic                     err_clr_i;

  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic                     a_valid, a_locked, a_err;
  logic                     b_valid, b_locked, b_err;
  logic [7:0]               a_cnt;
  logic [1:0]               b_cnt;

  iq_deinterleave #(.DATA_W(DATA_W), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .re_p_im_i (re_p_im_i),
    .err_clr_i (err_clr_i),
    .data_re_o (a_re),
    .data_im_o (a_im),
    .valid_o   (a_valid),
    .locked_o  (a_locked),
    .err_o     (a_err),
    .err_cnt_o (a_cnt)
  );

  iq_deinterleave #(.DATA_W(DATA_W), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(2)) dut_w2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .re_p_im_i (re_p_im_i),
    .err_clr_i (err_clr_i),
    .data_re_o (b_re),
    .data_im_o (b_im),
    .valid_o   (b_valid),
    .locked_o  (b_locked),
    .err_o     (b_err),
    .err_cnt_o (b_cnt)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: lock is "at least LOCK_CNT alternations since the last
  // repeated flag (or reset)"; a pair is an im word right after a re word
  // while locked, and its real part is simply the previous word.
  bit          m_prev_vld;
  bit          m_prev_flag;
  logic [15:0] m_prev_data;
  int          m_run;
  bit          m_valid;
  bit          m_err;
  int          m_cnt8;
  int          m_cnt2;
  iq_sample_t  m_pair;

  int          cyc;
  int          first_lock, first_valid;
  logic [15:0] first_re, first_im;
  bit          cur_flag;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_vld  = 1'b0;
    m_prev_flag = 1'b0;
    m_prev_data = '0;
    m_run       = 0;
    m_valid     = 1'b0;
    m_err       = 1'b0;
    m_cnt8      = 0;
    m_cnt2      = 0;
    m_pair      = '0;
    cyc         = 0;
  endtask

  task automatic model_sample(input bit flag, input logic [15:0] data, input bit clr);
    bit locked_before, same, alt;
    locked_before = (m_run >= LOCK_CNT);
    same          = m_prev_vld && (flag == m_prev_flag);
    alt           = m_prev_vld && (flag != m_prev_flag);
    m_err         = same && locked_before;
    m_valid       = locked_before && !flag && m_prev_flag;
    if (m_valid) begin
      m_pair.re = m_prev_data;
      m_pair.im = data;
    end
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (m_err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
    m_run       = alt ? m_run + 1 : 0;
    m_prev_vld  = 1'b1;
    m_prev_flag = flag;
    m_prev_data = data;
  endtask

  task automatic check_outputs();
    bit exp_lock;
    exp_lock = (m_run >= LOCK_CNT);
    chk("valid",    16'(a_valid),  16'(m_valid));
    chk("locked",   16'(a_locked), 16'(exp_lock));
    chk("err",      16'(a_err),    16'(m_err));
    chk("err_cnt",  16'(a_cnt),    16'(m_cnt8));
    chk("data_re",  a_re,          m_pair.re);
    chk("data_im",  a_im,          m_pair.im);
    chk("w2_valid", 16'(b_valid),  16'(m_valid));
    chk("w2_cnt",   16'(b_cnt),    16'(m_cnt2));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  16'(a_valid),  16'h0);
    chk({tag, "_locked"}, 16'(a_locked), 16'h0);
    chk({tag, "_err"},    16'(a_err),    16'h0);
    chk({tag, "_cnt"},    16'(a_cnt),    16'h0);
    chk({tag, "_re"},     a_re,          16'h0);
    chk({tag, "_im"},     a_im,          16'h0);
    chk({tag, "_w2cnt"},  16'(b_cnt),    16'h0);
    chk({tag, "_w2lock"}, 16'(b_locked), 16'h0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit flag, input logic [15:0] data, input bit clr);
    re_p_im_i = flag;
    data_i    = data;
    err_clr_i = clr;
    @(posedge clk_i);
    model_sample(flag, data, clr);
    #1;
    check_outputs();
    if (a_locked && first_lock < 0) first_lock = cyc + 1;
    if (a_valid && first_valid < 0) begin
      first_valid = cyc + 1;
      first_re    = a_re;
      first_im    = a_im;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      cur_flag = ~cur_flag;
      step(cur_flag, 16'($urandom), 1'b0);
    end
  endtask

  task automatic dup(input bit clr);
    step(cur_flag, 16'($urandom), clr);
  endtask

  task automatic do_reset(input string tag);
    rst_i     = 1'b1;
    re_p_im_i = 1'b0;
    data_i    = '0;
    err_clr_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_zero(tag);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i     = 1'b1;
    data_i    = '0;
    re_p_im_i = 1'b0;
    err_clr_i = 1'b0;
    model_reset();
    first_lock  = -1;
    first_valid = -1;
    first_re    = '0;
    first_im    = '0;
    @(negedge clk_i);

    // 1: alternating from cycle 0, re=100+k, im=-100-k
    do_reset("t1_rst");
    first_lock  = -1;
    first_valid = -1;
    for (int k = 0; k < 14; k++) begin
      if (k % 2 == 0) step(1'b1, 16'(100 + k), 1'b0);
      else            step(1'b0, 16'(-100 - k), 1'b0);
    end
    cur_flag = 1'b0;
    chk("t1_lock_cycle",  16'(first_lock),  16'd5);
    chk("t1_valid_cycle", 16'(first_valid), 16'd6);
    chk("t1_first_re",    first_re,         16'(104));
    chk("t1_first_im",    first_im,         16'(-105));

    // 2: stream leading with an imaginary word
    do_reset("t2_rst");
    cur_flag = 1'b1;
    feed(4);
    chk("t2_not_locked", 16'(a_locked), 16'h0);
    feed(1);
    chk("t2_locked", 16'(a_locked), 16'h1);
    feed(16);

    // 3: two consecutive real words after lock
    if (cur_flag) feed(1);
    feed(1);
    dup(1'b0);
    chk("t3_err",    16'(a_err),    16'h1);
    chk("t3_cnt",    16'(a_cnt),    16'h1);
    chk("t3_locked", 16'(a_locked), 16'h0);
    chk("t3_valid",  16'(a_valid),  16'h0);
    feed(3);
    chk("t3_relock_early", 16'(a_locked), 16'h0);
    feed(1);
    chk("t3_relock", 16'(a_locked), 16'h1);
    feed(6);

    // 4: saturation of the 2-bit counter, then clear against an error
    do_reset("t4_rst");
    cur_flag = 1'b0;
    feed(6);
    for (int e = 0; e < 5; e++) begin
      dup(1'b0);
      feed(6);
    end
    chk("t4_sat_w2", 16'(b_cnt), 16'd3);
    chk("t4_cnt_w8", 16'(a_cnt), 16'd5);
    dup(1'b1);
    chk("t4_clr_err",  16'(a_err), 16'h1);
    chk("t4_clr_cnt",  16'(a_cnt), 16'h0);
    chk("t4_clr_w2",   16'(b_cnt), 16'h0);
    feed(6);

    // 5: asynchronous reset just after a real word while locked
    if (cur_flag) feed(1);
    chk("t5_pre_locked", 16'(a_locked), 16'h1);
    re_p_im_i = 1'b1;
    data_i    = 16'sh1234;
    @(posedge clk_i);
    model_sample(1'b1, 16'h1234, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_zero("t5_async");
    @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    cur_flag = 1'b1;
    feed(12);

    // 6: extreme values pass bit-exact
    if (cur_flag) feed(1);
    step(1'b1, 16'h8000, 1'b0);
    step(1'b0, 16'h7fff, 1'b0);
    cur_flag = 1'b0;
    chk("t6_valid", 16'(a_valid), 16'h1);
    chk("t6_re",    a_re,         16'h8000);
    chk("t6_im",    a_im,         16'h7fff);
    feed(1);
    chk("t6_valid_once", 16'(a_valid), 16'h0);
    chk("t6_re_hold",    a_re,         16'h8000);

    // Random phase: occasional repeated flags and clears
    for (int i = 0; i < 300; i++) begin
      bit rep, clr;
      rep = ($urandom_range(7) == 0);
      clr = ($urandom_range(15) == 0);
      if (!rep) cur_flag = ~cur_flag;
      step(cur_flag, 16'($urandom), clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
